// File: rtl/sqrt_req.sv
// sqrt_req: turns an operand stream into square-root table lookups.
// Each operand becomes a memory address. Credits limit the number of requests
// in flight, and the memory responses are buffered in a FIFO so that results
// leave in the same order the operands arrived.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   in_valid/in_ready/in_data         operand stream (W_IN)
//   addr1_valid/addr1_ready/addr1_data  memory read request (W_ADDR)
//   data1_valid/data1_ready/data1     memory read response (W_DATA)
//   out_valid/out_ready/out_data      result stream (W_DATA)
//   busy                              any request held, in flight or buffered
//
// Build option: SQRT_REQ_CLAMP_EN. When defined, an operand too large for the
// address space clamps to the top address. When undefined, the operand is
// truncated to its low address bits.
module sqrt_req #(
  parameter int unsigned W_DATA    = 16,
  parameter int unsigned W_ADDR    = 8,
  parameter int unsigned W_IN      = 12,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IN-1:0]   in_data,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] out_data,
  output logic              busy
);

  localparam int unsigned AW = $clog2(MAX_OUTST);
  localparam int unsigned CW = AW + 1;

  logic              run_q;
  logic              stg_full_q;
  logic [W_ADDR-1:0] stg_addr_q;
  logic [CW-1:0]     cnt_q;
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [W_DATA-1:0] mem_q [MAX_OUTST];

  logic [W_ADDR-1:0] addr_c;
  logic              in_fire;
  logic              addr_fire;
  logic              wr_en;
  logic              rd_en;
  logic              fifo_empty;
  logic              fifo_full;

  // Operand to address mapping
`ifdef SQRT_REQ_CLAMP_EN
  always_comb begin
    addr_c = in_data[W_ADDR-1:0];
    if ((in_data >> W_ADDR) != '0) addr_c = '1;
  end
`else
  logic unused_in_hi;
  assign unused_in_hi = ^in_data;
  assign addr_c       = in_data[W_ADDR-1:0];
`endif

  // Handshakes. A request is only offered while a credit is free.
  assign addr1_valid = stg_full_q && (cnt_q < CW'(MAX_OUTST));
  assign addr_fire   = addr1_valid && addr1_ready;
  assign in_ready    = run_q && (!stg_full_q || addr_fire);
  assign in_fire     = in_valid && in_ready;
  assign addr1_data  = stg_addr_q;

  // The credits guarantee FIFO space, so the response side never stalls.
  assign data1_ready = run_q;
  assign wr_en       = data1_valid && data1_ready;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign out_valid   = !fifo_empty;
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_en       = out_valid && out_ready;

  assign busy = stg_full_q || (cnt_q != '0);

  // Ready enable: low throughout reset, high from the first edge out of reset
  always_ff @(posedge clk) begin
    run_q <= rst;
  end

  // Address stage register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_full_q <= 1'b0;
      stg_addr_q <= '0;
    end else if (in_fire) begin
      stg_full_q <= 1'b1;
      stg_addr_q <= addr_c;
    end else if (addr_fire) begin
      stg_full_q <= 1'b0;
    end
  end

  // Credit counter: one credit per request, returned when its result leaves
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      case ({addr_fire, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Response FIFO. The storage is cleared so that out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(MAX_OUTST); i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data1;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr_en && fifo_full));

endmodule

// File: tb/tb_sqrt_req.sv
// Directed testbench for sqrt_req, using a 1-cycle square-root table memory.
module tb_sqrt_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        addr1_valid;
  logic        addr1_ready;
  logic [7:0]  addr1_data;
  logic        data1_valid;
  logic        data1_ready;
  logic [15:0] data1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [11:0] in_q[$];
  logic [7:0]  addr_log[$];
  logic [15:0] out_log[$];
  logic        in_fire_s = 1'b0;
  int          stall_cnt = 0;

  always #5 clk = ~clk;

  sqrt_req dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .addr1_valid(addr1_valid), .addr1_ready(addr1_ready), .addr1_data(addr1_data),
    .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  function automatic logic [15:0] isqrt(input logic [7:0] a);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(a)) r++;
    return 16'(r);
  endfunction

  function automatic logic [7:0] addr_of(input logic [11:0] x);
`ifdef SQRT_REQ_CLAMP_EN
    return (x > 12'h0FF) ? 8'hFF : x[7:0];
`else
    return x[7:0];
`endif
  endfunction

  // Square-root table memory with 1-cycle read latency
  always @(posedge clk) begin
    if (!rst) begin
      data1_valid <= 1'b0;
      data1       <= '0;
    end else begin
      data1_valid <= addr1_valid && addr1_ready;
      data1       <= isqrt(addr1_data);
    end
  end

  // Record transfers mid-cycle, where all handshake signals are stable
  always @(negedge clk) begin
    in_fire_s = rst && in_valid && in_ready;
    if (rst && addr1_valid && addr1_ready) addr_log.push_back(addr1_data);
    if (rst && out_valid && out_ready) out_log.push_back(out_data);
    if (rst && in_valid && !in_ready) stall_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    in_valid = (in_q.size() != 0);
    in_data  = in_valid ? in_q[0] : 12'h000;
  endtask

  task automatic push(input logic [11:0] x);
    in_q.push_back(x);
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (in_fire_s) void'(in_q.pop_front());
    drive();
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_log.size() >= n) break;
      tick();
    end
  endtask

  initial begin
    int ab, ob, sb, errs;
    logic [11:0] ops2[6];
    logic [15:0] exp2[6];
    logic [11:0] rops[100];

    ops2 = '{12'd0, 12'd1, 12'd4, 12'd15, 12'd16, 12'd200};
    exp2 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd14};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; addr1_ready = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_addr1_valid", 32'(addr1_valid), 32'd0);
    chk("rst_data1_ready", 32'(data1_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr1_data", 32'(addr1_data), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_data1_ready", 32'(data1_ready), 32'd1);

    // Single request: 9 -> address 9 -> root 3
    push(12'd9);
    tick();
    chk("single_addr1_valid", 32'(addr1_valid), 32'd1);
    chk("single_addr1_data", 32'(addr1_data), 32'd9);
    tick(); tick();
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'd3);
    chk("single_busy_held", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_busy_idle", 32'(busy), 32'd0);
    chk("single_out_drained", 32'(out_valid), 32'd0);

    // Back-pressure: only MAX_OUTST requests issue while the output stalls
    ab = addr_log.size(); ob = out_log.size();
    for (int i = 0; i < 6; i++) push(ops2[i]);
    for (int i = 0; i < 20; i++) tick();
    chk("bp_addr_count", 32'(addr_log.size() - ab), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_left_waiting", 32'(in_q.size()), 32'd1);
    out_ready = 1'b1;
    wait_out(ob + 6, 100);
    chk("bp_out_count", 32'(out_log.size() - ob), 32'd6);
    for (int i = 0; i < 6; i++)
      if (ob + i < out_log.size()) chk($sformatf("bp_out%0d", i), 32'(out_log[ob + i]), 32'(exp2[i]));

    // Memory stall: address held steady, second operand waits
    ab = addr_log.size(); ob = out_log.size();
    addr1_ready = 1'b0;
    push(12'h042); push(12'h017);
    tick();
    chk("stall_addr1_valid", 32'(addr1_valid), 32'd1);
    chk("stall_addr1_data", 32'(addr1_data), 32'h42);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (addr1_data !== 8'h42 || in_ready !== 1'b0) errs++;
    end
    chk("stall_held_cycles", 32'(errs), 32'd0);
    addr1_ready = 1'b1;
    wait_out(ob + 2, 50);
    chk("stall_out_count", 32'(out_log.size() - ob), 32'd2);
    if (addr_log.size() >= ab + 2) begin
      chk("stall_addr_order0", 32'(addr_log[ab]), 32'h42);
      chk("stall_addr_order1", 32'(addr_log[ab + 1]), 32'h17);
    end
    if (out_log.size() >= ob + 2) begin
      chk("stall_out0", 32'(out_log[ob]), 32'd8);
      chk("stall_out1", 32'(out_log[ob + 1]), 32'd4);
    end

    // Operand wider than the address space
    ob = out_log.size();
    push(12'h3A5);
    tick();
`ifdef SQRT_REQ_CLAMP_EN
    chk("clamp_addr", 32'(addr1_data), 32'hFF);
`else
    chk("clamp_addr", 32'(addr1_data), 32'hA5);
`endif
    wait_out(ob + 1, 50);
    chk("clamp_out_count", 32'(out_log.size() - ob), 32'd1);
    if (out_log.size() > ob) begin
`ifdef SQRT_REQ_CLAMP_EN
      chk("clamp_out", 32'(out_log[ob]), 32'd15);
`else
      chk("clamp_out", 32'(out_log[ob]), 32'd12);
`endif
    end

    // Reset with three results buffered and one in flight
    out_ready = 1'b0;
    ab = addr_log.size();
    for (int i = 0; i < 4; i++) push(12'(10 + i));
    for (int i = 0; i < 50; i++) begin
      if (addr_log.size() >= ab + 4) break;
      tick();
    end
    chk("mid_rst_issued", 32'(addr_log.size() - ab), 32'd4);
    chk("mid_rst_inflight", 32'(data1_valid), 32'd1);
    chk("mid_rst_buffered", 32'(out_valid), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    ob = out_log.size();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_rst_no_stale", 32'(out_log.size() - ob), 32'd0);

    // Streaming with all readies high
    ob = out_log.size(); sb = stall_cnt;
    for (int i = 0; i < 100; i++) begin
      rops[i] = 12'($urandom_range(0, 4095));
      in_q.push_back(rops[i]);
    end
    drive();
    for (int i = 0; i < 400; i++) begin
      if (out_log.size() >= ob + 100) break;
      tick();
    end
    chk("stream_no_stall", 32'(stall_cnt - sb), 32'd0);
    chk("stream_out_count", 32'(out_log.size() - ob), 32'd100);
    errs = 0;
    for (int i = 0; i < 100; i++)
      if (ob + i >= out_log.size() || out_log[ob + i] !== isqrt(addr_of(rops[i]))) errs++;
    chk("stream_out_values", 32'(errs), 32'd0);
    tick();
    chk("stream_busy_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
